// File: rtl/serial_uart_tx.sv
// serial_uart_tx: memory-mapped 8N1 UART transmitter. CPU writes land in a
// byte FIFO; a four-state shifter drains the FIFO onto the tx line, and a
// STATUS word (empty/full/busy/overflow/count) can be polled through dout.
module serial_uart_tx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx,
  output logic        busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;

  // Shifter / line state
  state_t        state_r, state_n;
  logic          tx_r, tx_n;
  logic [BW-1:0] baud_r, baud_n;
  logic [2:0]    bit_r, bit_n;
  logic [7:0]    shift_r, shift_n;

  // Decoded bus actions and FIFO handshakes
  logic          push_req_s;
  logic          stat_wr_s;
  logic          flush_s;
  logic          ovf_clr_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;
  logic          pop_s;
  logic [7:0]    head_s;
  logic [31:0]   status_s;

  // Reads have no side effects, and only a few address/data bits are decoded.
  logic          unused_s;
  assign unused_s = ^{re, addr[31:3], addr[1:0], din[31:8]};

  assign head_s = mem_r[rd_ptr_r];
  assign busy   = (state_r != IDLE) || !empty_s;
  assign tx     = tx_r;

  // Bus decode: DATA pushes, STATUS flush / overflow-clear, full-FIFO arbitration
  always_comb begin
    push_req_s = sel && we && !addr[2];
    stat_wr_s  = sel && we && addr[2];
    flush_s    = stat_wr_s && din[0];
    ovf_clr_s  = stat_wr_s && din[3];
    empty_s    = (count_r == CNT_ZERO);
    full_s     = (count_r == CNT_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
        count_r  <= CNT_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // FIFO byte storage
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= din[7:0];
    end
  end

  // Line FSM next-state: frame sequencing, baud timing and pop requests
  always_comb begin
    state_n = state_r;
    tx_n    = tx_r;
    baud_n  = baud_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_n = head_s;
          tx_n    = 1'b0;
          baud_n  = BAUD_ZERO;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_n  = BAUD_ZERO;
          bit_n   = 3'd0;
          tx_n    = shift_r[0];
          state_n = DATA;
        end else begin
          baud_n = baud_r + BW'(1);
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_n = BAUD_ZERO;
          if (bit_r == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift_r[7:1]};
            bit_n   = bit_r + 3'd1;
            tx_n    = shift_r[1];
          end
        end else begin
          baud_n = baud_r + BW'(1);
        end
      end
      STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_n = BAUD_ZERO;
          if (!empty_s) begin
            // Chain straight into the next start bit: no idle gap.
            pop_s   = 1'b1;
            shift_n = head_s;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_r + BW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        baud_n  = BAUD_ZERO;
        state_n = IDLE;
      end
    endcase
  end

  // Line FSM state register; tx is registered so the line never glitches
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_r <= IDLE;
      tx_r    <= 1'b1;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_n;
      tx_r    <= tx_n;
      baud_r  <= baud_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  // Read mux: STATUS word when selected at addr[2]=1, zero otherwise
  always_comb begin
    status_s         = 32'h0000_0000;
    status_s[0]      = empty_s;
    status_s[1]      = full_s;
    status_s[2]      = busy;
    status_s[3]      = ovf_r;
    status_s[4 +: CW] = count_r;
    if (!sel) begin
      dout = 32'h0000_0000;
    end else if (addr[2]) begin
      dout = status_s;
    end else begin
      dout = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_serial_uart_tx.sv
// tb_serial_uart_tx: scoreboard bench. Accepted bytes are queued when written;
// a line monitor decodes every frame off tx and compares it sample-by-sample
// against the 8N1 waveform built from the queued byte.
module tb_serial_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic        clock = 1'b0;
  logic        clrn  = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] din   = 32'h0;
  logic [31:0] dout;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model / scoreboard state
  logic [7:0] sb_q[$];
  bit         ovf_m = 1'b0;

  // Monitor state
  bit               mon_active = 1'b0;
  bit               mon_have   = 1'b0;
  int               mon_idx    = 0;
  logic [7:0]       mon_exp    = 8'h00;
  logic [FRAME-1:0] mon_wave;
  int               frames_started = 0;
  int               frames_done    = 0;
  int               starts_q[$];

  serial_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .clrn  (clrn),
    .sel   (sel),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  initial begin : cycle_counter
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, got, exp);
    end
  endtask

  // Ideal 8N1 line waveform for one byte, DIV samples per bit.
  function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] b);
    logic [FRAME-1:0] w;
    logic v;
    w = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else             v = b[k-1];
      for (int j = 0; j < DIV; j++) w[k*DIV + j] = v;
    end
    return w;
  endfunction

  // True right after the clock edge on which a new frame's start bit began.
  function automatic bit pop_now();
    return (clrn === 1'b1) && !mon_active && (tx === 1'b0);
  endfunction

  // Expected STATUS word from the model (valid just after an active edge).
  function automatic logic [31:0] status_exp();
    int n;
    logic b;
    logic [31:0] s;
    n = sb_q.size() - (pop_now() ? 1 : 0);
    b = mon_active || pop_now() || (n != 0);
    s = 32'h0;
    s[0] = (n == 0);
    s[1] = (n == DEPTH);
    s[2] = b;
    s[3] = ovf_m;
    s[4 +: 5] = n[4:0];
    return s;
  endfunction

  // Apply the effect of a sampled bus write to the model.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] h;
    if (!a[2]) begin
      if (sb_q.size() >= DEPTH && !pop_now()) ovf_m = 1'b1;
      else sb_q.push_back(d[7:0]);
    end else begin
      if (d[0]) begin
        if (pop_now()) begin
          h = sb_q[0];
          sb_q.delete();
          sb_q.push_back(h);
        end else begin
          sb_q.delete();
        end
      end
      if (d[3]) ovf_m = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; din = d;
    @(posedge clock);
    #1;
    model_write(a, d);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; re = 1'b1; addr = a;
    #1;
    check(name, dout, exp);
    sel = 1'b0; re = 1'b0; addr = 32'h0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || mon_active || tx !== 1'b1) && k < max) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (k >= max) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got queue=%0d active=%0d after %0d cycles, want drained", name, sb_q.size(), mon_active, max);
    end
  endtask

  // Line monitor: detects start bits, pops the scoreboard, compares each frame.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (clrn !== 1'b1) begin
        mon_active = 1'b0;
        mon_idx    = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          frames_started++;
          starts_q.push_back(cyc);
          mon_wave    = '0;
          mon_wave[0] = tx;
          mon_idx     = 1;
          mon_active  = 1'b1;
          if (sb_q.size() != 0) begin
            mon_exp  = sb_q.pop_front();
            mon_have = 1'b1;
          end else begin
            mon_have = 1'b0;
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got start bit at cycle %0d, want idle line", cyc);
          end
        end
      end else begin
        mon_wave[mon_idx] = tx;
        mon_idx++;
        if (mon_idx == FRAME) begin
          mon_active = 1'b0;
          frames_done++;
          if (mon_have) begin
            checks++;
            if (mon_wave !== exp_wave(mon_exp)) begin
              errors++;
              $display("FAIL frame_0x%02h: got wave=%h want wave=%h", mon_exp, mon_wave, exp_wave(mon_exp));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion by cycle %0d, want completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int fr0;
    int ns0;
    int fs;
    int bad;
    logic [7:0] b;
    int gap;

    // Reset
    clrn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clrn = 1'b1;
    wait_cycles(1);
    read_check("reset_status", 32'h4, 32'h0000_0001);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Single byte: tx falls one edge after the push, busy clears 100 clocks later
    bus_write(32'h0, 32'h55);
    check("single_no_fall_yet", {31'd0, tx}, 32'd1);
    read_check("single_status_pushed", 32'h4, status_exp());
    wait_cycles(1);
    check("single_fall", {31'd0, tx}, 32'd0);
    wait_cycles(FRAME - 1);
    check("single_busy_last", {31'd0, busy}, 32'd1);
    wait_cycles(1);
    check("single_busy_clear", {31'd0, busy}, 32'd0);
    read_check("single_status_end", 32'h4, 32'h0000_0001);

    // Overflow: 17 writes while the first frame is in flight, then clear overflow
    fr0 = frames_done;
    ns0 = starts_q.size();
    bus_write(32'h0, 32'h77);
    wait_cycles(2);
    for (int i = 0; i < 17; i++) bus_write(32'h0, i);
    read_check("ovf_status", 32'h4, status_exp());
    bus_write(32'h4, 32'h8);
    read_check("ovf_cleared", 32'h4, status_exp());
    wait_drain("ovf_drain", 3000);
    check("ovf_frames", frames_done - fr0, 32'd17);
    bad = 0;
    for (int i = ns0 + 1; i < ns0 + 17 && i < starts_q.size(); i++) begin
      if (starts_q[i] - starts_q[i-1] != FRAME) bad++;
    end
    check("ovf_back_to_back_gaps", bad, 32'd0);
    wait_cycles(1);
    check("ovf_busy_end", {31'd0, busy}, 32'd0);

    // Flush during the first frame's DATA phase
    fr0 = frames_done;
    bus_write(32'h0, 32'hA5);
    bus_write(32'h0, 32'h3C);
    bus_write(32'h0, 32'h0F);
    wait_cycles(30);
    bus_write(32'h4, 32'h1);
    read_check("flush_status", 32'h4, status_exp());
    wait_drain("flush_drain", 500);
    fs = frames_started;
    wait_cycles(150);
    check("flush_one_frame", frames_done - fr0, 32'd1);
    check("flush_no_more", frames_started - fs, 32'd0);
    read_check("flush_status_end", 32'h4, status_exp());

    // Asynchronous reset in the middle of a DATA bit
    bus_write(32'h0, 32'h96);
    wait_cycles(45);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_tx_high", {31'd0, tx}, 32'd1);
    sb_q.delete();
    ovf_m = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    clrn = 1'b1;
    wait_cycles(1);
    read_check("arst_status", 32'h4, 32'h0000_0001);
    fs = frames_started;
    wait_cycles(200);
    check("arst_no_residual", frames_started - fs, 32'd0);
    check("arst_tx_idle", {31'd0, tx}, 32'd1);

    // Decode: unselected write ignored, DATA read returns 0 with no side effect
    @(negedge clock);
    sel = 1'b0; we = 1'b1; addr = 32'h0; din = 32'h5A;
    #1;
    check("dec_dout_unsel", dout, 32'h0);
    @(posedge clock);
    #1;
    we = 1'b0; din = 32'h0;
    read_check("dec_status_after_unsel", 32'h4, status_exp());
    read_check("dec_data_read", 32'h0, 32'h0);
    wait_cycles(1);
    read_check("dec_status_after_read", 32'h4, status_exp());

    // Randomized traffic, enough to overrun the FIFO occasionally
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(32'h0, {24'h0, b});
      gap = $urandom_range(0, 40);
      if (gap > 0) wait_cycles(gap);
      if (i % 6 == 5) read_check("rand_status", 32'h4, status_exp());
    end
    wait_drain("rand_drain", 4000);
    wait_cycles(1);
    read_check("rand_status_end", 32'h4, status_exp());
    check("rand_busy_end", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
